// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read-channel arbiter: icache and dcache share one AR/R path,
// one burst in flight at a time, round-robin on simultaneous requests.
module axi_rd_arbiter #(
    parameter logic [3:0] ID_I    = 4'd0,
    parameter logic [3:0] ID_D    = 4'd1,
    parameter logic [2:0] ARSIZE  = 3'd2,
    parameter logic [1:0] ARBURST = 2'b01
) (
    input  logic        clk,
    input  logic        resetn,
    // icache
    input  logic [31:0] i_araddr,
    input  logic [7:0]  i_arlen,
    input  logic        i_arvalid,
    output logic        i_arready,
    output logic [31:0] i_rdata,
    output logic        i_rlast,
    output logic        i_rvalid,
    input  logic        i_rready,
    // dcache
    input  logic [31:0] d_araddr,
    input  logic [7:0]  d_arlen,
    input  logic        d_arvalid,
    output logic        d_arready,
    output logic [31:0] d_rdata,
    output logic        d_rlast,
    output logic        d_rvalid,
    input  logic        d_rready,
    // AXI read master
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    // grant / last_grant encoding: 0 = icache, 1 = dcache
    state_e state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_grant_q, last_grant_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        arvalid      = 1'b0;
        araddr       = '0;
        arlen        = '0;
        arid         = '0;
        rready       = 1'b0;
        i_arready    = 1'b0;
        d_arready    = 1'b0;
        i_rvalid     = 1'b0;
        d_rvalid     = 1'b0;
        i_rlast      = 1'b0;
        d_rlast      = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_arvalid || d_arvalid) begin
                    state_d = ADDR;
                    if (i_arvalid && d_arvalid) grant_d = ~last_grant_q;
                    else                        grant_d = d_arvalid;
                end
            end

            ADDR: begin
                // Requester holds its address stable until arready, so the
                // live inputs are muxed straight through by the registered grant.
                arvalid = 1'b1;
                araddr  = grant_q ? d_araddr : i_araddr;
                arlen   = grant_q ? d_arlen  : i_arlen;
                arid    = grant_q ? ID_D     : ID_I;
                if (grant_q) d_arready = arready;
                else         i_arready = arready;
                if (arready) begin
                    state_d      = DATA;
                    last_grant_d = grant_q;
                end
            end

            DATA: begin
                arid   = grant_q ? ID_D : ID_I;
                rready = grant_q ? d_rready : i_rready;
                if (grant_q) begin
                    d_rvalid = rvalid;
                    d_rlast  = rlast;
                end else begin
                    i_rvalid = rvalid;
                    i_rlast  = rlast;
                end
                if (rvalid && rready && rlast) state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // Data is fanned out unqualified; only the granted side sees rvalid.
    assign i_rdata = rdata;
    assign d_rdata = rdata;
    assign arsize  = ARSIZE;
    assign arburst = ARBURST;

    logic unused_rresp;
    assign unused_rresp = ^rresp;

    a_rid_matches_grant: assert property (
        @(posedge clk) disable iff (!resetn)
        (state_q == DATA && rvalid) |-> (rid == arid)
    );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized + directed bench for axi_rd_arbiter: a protocol-level model of the
// arbitration rules and a per-master scoreboard of expected bursts.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] i_araddr, d_araddr;
    logic [7:0]  i_arlen, d_arlen;
    logic        i_arvalid, d_arvalid, i_arready, d_arready;
    logic [31:0] i_rdata, d_rdata;
    logic        i_rlast, d_rlast, i_rvalid, d_rvalid, i_rready, d_rready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;

    axi_rd_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arvalid(i_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
        .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arvalid(d_arvalid), .d_arready(d_arready),
        .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } tx_t;

    tx_t iq[$], dq[$];
    int  arid_log[$];
    int  checks = 0, errors = 0;
    // 0 = force low, 1 = force high, 2 = random, 3 = toggle (rready only)
    int  ar_mode = 2, rv_mode = 2, irr_mode = 2, drr_mode = 2;
    int  done_i = 0, done_d = 0;
    int  mbeat = 0;

    function automatic logic [31:0] beat_data(logic [31:0] a, int b);
        return a ^ 32'(b + 1);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- AXI slave model ----------------
    logic        s_busy, s_ar_hs, s_r_hs;
    int          s_beat;
    logic [31:0] s_base, s_abase;
    logic [7:0]  s_len, s_alen;
    logic [3:0]  s_id, s_aid;

    initial begin
        s_busy = 0; s_beat = 0; s_base = 0; s_len = 0; s_id = 0;
        arready = 0; rvalid = 0; rlast = 0; rdata = 0; rid = 0; rresp = 0;
        forever begin
            @(negedge clk);
            s_ar_hs = arvalid & arready;
            s_r_hs  = rvalid & rready;
            s_abase = araddr; s_alen = arlen; s_aid = arid;
            @(posedge clk); #1;
            if (!resetn) begin
                s_busy = 0; rvalid = 0; rlast = 0; arready = 0;
                continue;
            end
            if (s_r_hs) begin
                rvalid = 0;
                if (s_beat == int'(s_len)) s_busy = 0;
                else s_beat++;
            end
            if (s_ar_hs) begin
                s_busy = 1; s_beat = 0; s_base = s_abase; s_len = s_alen; s_id = s_aid;
            end
            if (s_busy && !rvalid) rvalid = (rv_mode == 1) || ($urandom_range(0, 3) != 0);
            rdata   = beat_data(s_base, s_beat);
            rlast   = s_busy && (s_beat == int'(s_len));
            rid     = s_id;
            rresp   = 2'b00;
            arready = !s_busy && (ar_mode == 1 || (ar_mode == 2 && $urandom_range(0, 1) == 1));
        end
    end

    // ---------------- master rready drivers ----------------
    initial begin
        i_rready = 0; d_rready = 0;
        forever begin
            @(posedge clk); #1;
            i_rready = (irr_mode == 1) ? 1'b1 : (irr_mode == 3) ? ~i_rready : ($urandom_range(0, 3) != 0);
            d_rready = (drr_mode == 1) ? 1'b1 : (drr_mode == 3) ? ~d_rready : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- monitor / reference model ----------------
    // ph: 0 idle, 1 address phase, 2 data phase, 3 mandatory idle after rlast
    int          ph = 0;
    logic        exp_m, last_served = 1'b1;
    logic        prev_iv = 0, prev_dv = 0, exp_av, exp_rr, got_last;
    logic [31:0] got_data;
    tx_t         cur;

    initial forever begin
        @(negedge clk);
        if (!resetn) begin
            ph = 0; last_served = 1'b1; mbeat = 0;
            chk("rst_outputs", {arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast}, 0);
        end else begin
            if (ph == 0 || ph == 3) begin
                exp_av = (ph == 0) && (prev_iv || prev_dv);
                chk("ar_latency", arvalid, exp_av);
                if (arvalid && exp_av) begin
                    exp_m = (prev_iv && prev_dv) ? ~last_served : prev_dv;
                    if ((exp_m && dq.size() == 0) || (!exp_m && iq.size() == 0)) begin
                        chk("ar_no_request", 1, 0);
                        ph = 0;
                    end else begin
                        cur = exp_m ? dq[0] : iq[0];
                        ph = 1;
                    end
                end else begin
                    chk("idle_outputs", {rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast}, 0);
                    ph = 0;
                end
            end
            if (ph == 1) begin
                chk("arvalid", arvalid, 1);
                chk("araddr", araddr, cur.addr);
                chk("arlen", arlen, cur.len);
                chk("arid", arid, exp_m ? 1 : 0);
                chk("arsize", arsize, 2);
                chk("arburst", arburst, 1);
                chk("i_arready", i_arready, !exp_m && arready);
                chk("d_arready", d_arready, exp_m && arready);
                chk("addr_r_quiet", {rready, i_rvalid, d_rvalid}, 0);
                if (arready) begin
                    ph = 2; last_served = exp_m; mbeat = 0;
                    arid_log.push_back(int'(arid));
                end
            end else if (ph == 2) begin
                exp_rr = exp_m ? d_rready : i_rready;
                chk("rready", rready, exp_rr);
                chk("data_ar_quiet", {arvalid, i_arready, d_arready}, 0);
                if (exp_m) begin
                    chk("d_rvalid", d_rvalid, rvalid);
                    chk("d_rlast", d_rlast, rlast);
                    chk("i_quiet", {i_rvalid, i_rlast}, 0);
                    got_data = d_rdata; got_last = d_rlast;
                end else begin
                    chk("i_rvalid", i_rvalid, rvalid);
                    chk("i_rlast", i_rlast, rlast);
                    chk("d_quiet", {d_rvalid, d_rlast}, 0);
                    got_data = i_rdata; got_last = i_rlast;
                end
                if (rvalid && exp_rr) begin
                    chk("rdata", got_data, beat_data(cur.addr, mbeat));
                    chk("rlast_pos", got_last, mbeat == int'(cur.len));
                    if (mbeat == int'(cur.len)) begin
                        if (exp_m) begin void'(dq.pop_front()); done_d++; end
                        else       begin void'(iq.pop_front()); done_i++; end
                        ph = 3;
                    end else mbeat++;
                end
            end
        end
        prev_iv = i_arvalid;
        prev_dv = d_arvalid;
    end

    // ---------------- stimulus ----------------
    task automatic do_req(input bit m, input logic [31:0] a, input logic [7:0] l, input bit wait_done);
        tx_t t;
        int  d0;
        bit  got;
        t.addr = a; t.len = l;
        @(posedge clk); #1;
        d0 = m ? done_d : done_i;
        if (m) begin dq.push_back(t); d_araddr = a; d_arlen = l; d_arvalid = 1; end
        else   begin iq.push_back(t); i_araddr = a; i_arlen = l; i_arvalid = 1; end
        got = 0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(negedge clk); #1;
            got = m ? d_arready : i_arready;
        end
        if (!got) chk(m ? "d_ar_timeout" : "i_ar_timeout", 0, 1);
        @(posedge clk); #1;
        if (m) begin d_arvalid = 0; d_araddr = $urandom; d_arlen = 8'($urandom); end
        else   begin i_arvalid = 0; i_araddr = $urandom; i_arlen = 8'($urandom); end
        if (wait_done) begin
            got = 0;
            for (int k = 0; k < 5000 && !got; k++) begin
                @(negedge clk); #1;
                got = (m ? done_d : done_i) != d0;
            end
            if (!got) chk(m ? "d_burst_timeout" : "i_burst_timeout", 0, 1);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        resetn = 0;
        iq.delete(); dq.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    int n;
    logic got3;

    initial begin
        i_arvalid = 0; d_arvalid = 0; i_araddr = 0; d_araddr = 0; i_arlen = 0; d_arlen = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valids", {arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast}, 0);
        chk("reset_araddr", araddr, 0);
        chk("reset_arlen_arid", {arlen, arid}, 0);
        resetn = 1;

        // single icache burst, slave always ready
        ar_mode = 1; rv_mode = 1; irr_mode = 1; drr_mode = 1;
        do_req(0, 32'hBFC00000, 8'd7, 1);
        chk("t1_arid", arid_log[0], 0);

        // tie after reset goes to icache, then dcache, then icache again
        do_reset();
        n = arid_log.size();
        fork
            do_req(0, 32'h00002000, 8'd3, 1);
            do_req(1, 32'h80001000, 8'd3, 1);
        join
        fork
            do_req(0, 32'h00002100, 8'd1, 1);
            do_req(1, 32'h80001100, 8'd1, 1);
        join
        chk("tie1_first", arid_log[n], 0);
        chk("tie1_second", arid_log[n+1], 1);
        chk("tie2_first", arid_log[n+2], 0);

        // dcache address stall with icache arriving during it
        n = arid_log.size();
        ar_mode = 0;
        fork
            do_req(1, 32'h80002000, 8'd7, 1);
            begin repeat (2) @(posedge clk); #1; do_req(0, 32'h00003000, 8'd3, 1); end
            begin repeat (6) @(negedge clk); ar_mode = 1; end
        join
        chk("stall_first", arid_log[n], 1);
        chk("stall_second", arid_log[n+1], 0);

        // dcache rready toggling under continuous rvalid
        drr_mode = 3;
        do_req(1, 32'h80004000, 8'd7, 1);
        drr_mode = 1;

        // reset in the middle of an icache burst
        do_req(0, 32'h00005000, 8'd7, 0);
        got3 = 0;
        for (int k = 0; k < 200 && !got3; k++) begin
            @(negedge clk); #1;
            got3 = (mbeat == 3);
        end
        if (!got3) chk("midburst_timeout", 0, 1);
        #2 resetn = 0;
        #1;
        chk("async_rst_valids", {arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast}, 0);
        chk("async_rst_addr", araddr, 0);
        iq.delete(); dq.delete();
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        n = arid_log.size();
        do_req(0, 32'h00006000, 8'd3, 1);
        chk("post_rst_grant", arid_log[n], 0);

        // back-to-back dcache-only
        n = arid_log.size();
        do_req(1, 32'h80007000, 8'd3, 1);
        do_req(1, 32'h80007100, 8'd2, 1);
        chk("b2b_first", arid_log[n], 1);
        chk("b2b_second", arid_log[n+1], 1);

        // randomized traffic from both masters
        ar_mode = 2; rv_mode = 2; irr_mode = 2; drr_mode = 2;
        fork
            for (int k = 0; k < 25; k++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                do_req(0, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)), 1);
            end
            for (int j = 0; j < 25; j++) begin
                repeat ($urandom_range(0, 4)) @(posedge clk);
                do_req(1, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)), 1);
            end
        join
        repeat (4) @(posedge clk);
        chk("queues_drained", iq.size() + dq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Arbitrates the single AXI read channel between the instruction cache and the data cache.
- Each cache presents a cache-line burst read request (araddr/arlen/arvalid, r-channel handshake).
- The block grants one requester at a time, forwards its AR beat to the AXI bus, and routes R beats back to it until rlast.
- Grant is round-robin when both caches request in the same cycle.

Parameters:
- ID_I, 4'd0, arid driven for instruction-cache transactions
- ID_D, 4'd1, arid driven for data-cache transactions
- ARSIZE, 3'd2, arsize driven on every request (4-byte beats)
- ARBURST, 2'b01, arburst driven on every request (INCR)

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- i_araddr  in  32  icache request address
- i_arlen  in  8  icache burst length-1
- i_arvalid  in  1  icache request valid
- i_arready  out  1  icache address accepted
- i_rdata  out  32  read data to icache
- i_rlast  out  1  last beat to icache
- i_rvalid  out  1  beat valid to icache
- i_rready  in  1  icache ready for beat
- d_araddr, d_arlen, d_arvalid, d_arready, d_rdata, d_rlast, d_rvalid, d_rready: same directions, widths and meaning for the data cache
- arid  out  4  AXI read ID
- araddr  out  32  AXI address
- arlen  out  8  AXI burst length-1
- arsize  out  3  constant ARSIZE
- arburst  out  2  constant ARBURST
- arvalid  out  1  AXI address valid
- arready  in  1  AXI address ready
- rid  in  4  AXI read ID (used for checking only; routing is by grant)
- rdata  in  32  AXI data
- rresp  in  2  AXI response (ignored)
- rlast  in  1  AXI last beat
- rvalid  in  1  AXI beat valid
- rready  out  1  AXI beat ready

Behaviour:
- Reset: resetn low asynchronously forces the following, regardless of any in-flight transaction (the transaction is abandoned, not completed):
  - state=IDLE, grant=I, last_grant=D (so icache wins the first tie)
  - arvalid, rready, i_arready, d_arready, i_rvalid, d_rvalid, i_rlast, d_rlast all 0
  - araddr/arlen/arid are 0 while in IDLE
- State IDLE:
  - No bus outputs asserted.
  - Only d_arvalid: grant<=D. Only i_arvalid: grant<=I.
  - Both: grant<=opposite of last_grant.
  - Any request: ->ADDR next cycle.
- State ADDR:
  - arvalid=1; araddr/arlen/arid are driven combinationally from the granted master's registered selection (ID_I or ID_D).
  - Granted master's x_arready = arready. Other master's x_arready=0.
  - On arvalid&arready: ->DATA, last_grant<=grant.
- State DATA:
  - x_rdata=rdata; x_rvalid=rvalid; x_rlast=rlast for the granted master.
  - Other master's rvalid/rlast forced to 0; its rdata may equal rdata.
  - rready = granted master's x_rready.
  - On rvalid&rready&rlast: ->IDLE.
  - Beats with rvalid&~rready are held by the slave; the arbiter adds no buffering.
- Latency:
  - Request-to-arvalid is 1 cycle (IDLE->ADDR).
  - R path is zero-latency combinational.
  - After rlast there is 1 idle cycle before the next grant.
- Single outstanding transaction; no new AR is issued until rlast completes.
- A master's x_arvalid/araddr/arlen must stay stable until x_arready. The arbiter does not re-arbitrate in ADDR: a requester that deasserts early is a protocol violation, behaviour undefined.
- A requester not granted sees x_arready=0 and x_rvalid=0 and keeps waiting; round-robin guarantees it is granted within one transaction.
- Assertion (sim only): in DATA, rid == arid of the granted master.

Test Plan:
- Reset then i_arvalid=1, i_araddr=0xBFC00000, i_arlen=7, arready=1 on the 2nd cycle -> arvalid high 1 cycle after request, araddr=0xBFC00000, arid=0, i_arready pulses once; 8 beats 0x1..0x8 delivered only on i_rvalid, i_rlast on beat 8, state IDLE next cycle.
- Both request in the same cycle after reset (d_araddr=0x80001000) -> icache granted first. After its rlast, dcache granted with arid=1, araddr=0x80001000. A second simultaneous tie then goes to icache.
- dcache request with arready held 0 for 5 cycles -> arvalid/araddr stable all 5 cycles, d_arready=0 until arready=1. icache arriving meanwhile is not granted.
- rready backpressure: d_rready toggles 1,0,1,... over an 8-beat burst with rvalid=1 -> rready mirrors d_rready. Exactly 8 accepted beats, i_rvalid stays 0 throughout.
- resetn pulled low at beat 3 of a burst -> all valid/ready outputs 0 immediately (asynchronously). After release, a new icache request is granted normally.
- Back-to-back dcache-only requests -> grant stays D. Exactly one idle cycle between rlast and the next arvalid.
